weight_sram_arb: RTL and testbench
==================================

WEIGHT_SRAM_ARB -- requirements
Module: weight_sram_arb

Interface
Parameters:
REQ-001 The block SHALL have parameter AW, default 16, SRAM address width.
REQ-002 The block SHALL have parameter DW, default 16, SRAM data width.
REQ-003 The block SHALL have parameter STARVE_LIM, default 4, the reader wait cycles that force a read grant; legal range 1..15.

Ports:
REQ-004 The block SHALL have these ports; clocking is one clock, and reset is synchronous and active-high:
- i_clk  in  1  the only clock
- i_rst  in  1  synchronous, active-high reset
- i_wr_req  in  1  DMA write request
- i_wr_addr  in  AW  write address
- i_wr_data  in  DW  write data
- o_wr_gnt  out  1  write accepted this cycle
- i_rd0_req  in  1  conv weight loader read request
- i_rd0_addr  in  AW  read address
- o_rd0_gnt  out  1  read accepted this cycle
- o_rd0_data  out  DW  read data
- o_rd0_vld  out  1  o_rd0_data valid, 1-cycle pulse
- i_rd1_req  in  1  FC read request
- i_rd1_addr  in  AW  read address
- o_rd1_gnt  out  1  read accepted this cycle
- o_rd1_data  out  DW  read data
- o_rd1_vld  out  1  o_rd1_data valid, 1-cycle pulse
- o_sram_cs  out  1  SRAM chip select
- o_sram_we  out  1  SRAM write enable
- o_sram_addr  out  AW  SRAM address
- o_sram_din  out  DW  SRAM write data
- i_sram_dout  in  DW  SRAM read data, valid 1 cycle after a read command
- o_busy  out  1  command or read return in flight

Function
REQ-005 At most one of o_wr_gnt, o_rd0_gnt, o_rd1_gnt SHALL be high in any cycle.
REQ-006 Each grant SHALL be combinational from the current requests and registered arbiter state.
REQ-007 Requesters hold req/addr/data stable until their grant is high; the grant cycle is the acceptance cycle.
REQ-008 Priority per cycle SHALL be:
- (1) a starved reader (wait count == STARVE_LIM with req high); if both are starved, use the round-robin pointer;
- (2) write, if i_wr_req;
- (3) readers by round-robin pointer: a pointer value of 0 prefers rd0, 1 prefers rd1; the preferred reader wins if requesting, otherwise the other reader wins.
REQ-009 The round-robin pointer SHALL update only on a read grant, to the other reader (grant rd0 -> 1, grant rd1 -> 0).
REQ-010 Per-reader wait counter:
- increment each cycle req=1 and gnt=0, saturating at STARVE_LIM;
- clear when gnt=1 or req=0.
REQ-011 Command register: in cycle N+1 after a grant in cycle N, o_sram_cs=1, with o_sram_addr/o_sram_din/o_sram_we taken from the granted requester (we=1 for write, 0 for read).
REQ-012 With no grant in cycle N, cycle N+1 SHALL have o_sram_cs=0 and o_sram_we=0, and o_sram_addr/o_sram_din SHALL hold their previous values.
REQ-013 Read return: a 2-stage tag pipeline (valid + reader id) SHALL follow the command.
- i_sram_dout is sampled in cycle N+2 and registered into o_rdK_data.
- o_rdK_vld=1 in cycle N+3 for exactly one cycle.
- Fixed latency from grant to vld is 3 cycles.
REQ-014 o_rdK_data SHALL hold its last value until the next return to that reader.
REQ-015 Reads SHALL return in grant order; back-to-back grants give back-to-back vld pulses with no bubble and no loss.
REQ-016 Sustained throughput SHALL be one access per cycle.
REQ-017 A write followed next cycle by a read of the same address SHALL return the new data, since the SRAM is sequential and no bypass is needed.
REQ-018 o_busy SHALL be the OR of the command-register cs and both tag-pipeline valid bits.
REQ-019 Requests arriving in the same cycle SHALL obey REQ-008; losers keep waiting, with no drop and no duplicate grant.
REQ-020 A requester deasserting req without a grant SHALL be legal; its wait counter clears.
REQ-021 Address and data widths SHALL pass straight through with no arithmetic; counters SHALL be 4 bits.

Reset
REQ-022 While i_rst=1 at a posedge, all of the following SHALL clear:
- grants = 0;
- o_sram_cs/we = 0, o_sram_addr/din = 0;
- o_rd0/1_data = 0, o_rd0/1_vld = 0, o_busy = 0;
- rr pointer = 0, wait counters = 0, tag pipeline cleared.
REQ-023 Grants SHALL be forced low while i_rst=1.
REQ-024 Reads in flight when reset is asserted SHALL be discarded; no vld pulse may follow reset.

Verification
REQ-025 Single read: rd0 requests addr 0x0005 and SRAM model holds 0xBEEF -> gnt cycle 0, cs=1/we=0/addr=0x0005 cycle 1, o_rd0_vld=1 with data 0xBEEF cycle 3.
REQ-026 Write then read: write 0x0010<-0x1234 granted cycle 0, rd1 reads 0x0010 granted cycle 1 -> o_rd1_vld cycle 4 with data 0x1234.
REQ-027 Contention: wr, rd0 and rd1 all held high, STARVE_LIM=4 -> wr granted cycles 0-3, rd0 granted cycle 4, rd1 granted cycle 5, with rd1 starved then served by pointer.
REQ-028 Round-robin: rd0 and rd1 continuous, no write -> grants alternate rd0, rd1, rd0, ...; vld pulses alternate with 3-cycle offset and none are lost.
REQ-029 Reset mid-flight: rd0 granted cycle 0, i_rst=1 cycle 1 -> no o_rd0_vld ever, all outputs 0 cycle 2, and the first grant after release goes to rd0 (pointer 0).
REQ-030 Random stress: random requests for 10k cycles against a reference scoreboard -> grants one-hot, every read returns correct data in order, and no reader waits more than STARVE_LIM+1 cycles.

Source files
------------

// File: rtl/weight_sram_arb.sv
`default_nettype none
// ============================================================================
// weight_sram_arb : one-write / two-read arbiter for a single-port weight SRAM
// Rev 1.0
// ============================================================================
module weight_sram_arb #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_req,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_wr_gnt,
  input  logic          i_rd0_req,
  input  logic [AW-1:0] i_rd0_addr,
  output logic          o_rd0_gnt,
  output logic [DW-1:0] o_rd0_data,
  output logic          o_rd0_vld,
  input  logic          i_rd1_req,
  input  logic [AW-1:0] i_rd1_addr,
  output logic          o_rd1_gnt,
  output logic [DW-1:0] o_rd1_data,
  output logic          o_rd1_vld,
  output logic          o_sram_cs,
  output logic          o_sram_we,
  output logic [AW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_din,
  input  logic [DW-1:0] i_sram_dout,
  output logic          o_busy
);

  localparam logic [3:0] C_STARVE_LIM = 4'(STARVE_LIM);

  logic          r_rr_ptr;
  logic [3:0]    r_wait0;
  logic [3:0]    r_wait1;
  logic          w_starve0;
  logic          w_starve1;
  logic          w_gnt_wr;
  logic          w_gnt_rd0;
  logic          w_gnt_rd1;
  logic          w_any_gnt;

  logic          r_cs;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;

  logic          r_tag1_vld;
  logic          r_tag1_id;
  logic          r_tag2_vld;
  logic          r_tag2_id;
  logic [DW-1:0] r_rd0_data;
  logic [DW-1:0] r_rd1_data;
  logic          r_rd0_vld;
  logic          r_rd1_vld;

  assign w_starve0 = i_rd0_req && (r_wait0 == C_STARVE_LIM);
  assign w_starve1 = i_rd1_req && (r_wait1 == C_STARVE_LIM);

  // Starved readers beat the writer; the writer beats ordinary reads.
  always_comb begin
    w_gnt_wr  = 1'b0;
    w_gnt_rd0 = 1'b0;
    w_gnt_rd1 = 1'b0;
    if (!i_rst) begin
      if (w_starve0 && w_starve1) begin
        if (r_rr_ptr) w_gnt_rd1 = 1'b1;
        else          w_gnt_rd0 = 1'b1;
      end else if (w_starve0) begin
        w_gnt_rd0 = 1'b1;
      end else if (w_starve1) begin
        w_gnt_rd1 = 1'b1;
      end else if (i_wr_req) begin
        w_gnt_wr = 1'b1;
      end else if (i_rd0_req && i_rd1_req) begin
        if (r_rr_ptr) w_gnt_rd1 = 1'b1;
        else          w_gnt_rd0 = 1'b1;
      end else if (i_rd0_req) begin
        w_gnt_rd0 = 1'b1;
      end else if (i_rd1_req) begin
        w_gnt_rd1 = 1'b1;
      end
    end
  end

  assign w_any_gnt = w_gnt_wr | w_gnt_rd0 | w_gnt_rd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= 1'b0;
      r_wait0  <= 4'd0;
      r_wait1  <= 4'd0;
    end else begin
      if (w_gnt_rd0)      r_rr_ptr <= 1'b1;
      else if (w_gnt_rd1) r_rr_ptr <= 1'b0;

      if (i_rd0_req && !w_gnt_rd0) begin
        if (r_wait0 != C_STARVE_LIM) r_wait0 <= r_wait0 + 4'd1;
      end else begin
        r_wait0 <= 4'd0;
      end

      if (i_rd1_req && !w_gnt_rd1) begin
        if (r_wait1 != C_STARVE_LIM) r_wait1 <= r_wait1 + 4'd1;
      end else begin
        r_wait1 <= 4'd0;
      end
    end
  end

  // Address/data hold when idle; write data only changes on a write grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs   <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_cs <= w_any_gnt;
      r_we <= w_gnt_wr;
      if (w_gnt_wr) begin
        r_addr <= i_wr_addr;
        r_din  <= i_wr_data;
      end else if (w_gnt_rd0) begin
        r_addr <= i_rd0_addr;
      end else if (w_gnt_rd1) begin
        r_addr <= i_rd1_addr;
      end
    end
  end

  // Tag pipeline lines up with the SRAM's one-cycle read latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag1_vld <= 1'b0;
      r_tag1_id  <= 1'b0;
      r_tag2_vld <= 1'b0;
      r_tag2_id  <= 1'b0;
      r_rd0_vld  <= 1'b0;
      r_rd1_vld  <= 1'b0;
      r_rd0_data <= '0;
      r_rd1_data <= '0;
    end else begin
      r_tag1_vld <= w_gnt_rd0 | w_gnt_rd1;
      r_tag1_id  <= w_gnt_rd1;
      r_tag2_vld <= r_tag1_vld;
      r_tag2_id  <= r_tag1_id;
      r_rd0_vld  <= r_tag2_vld && !r_tag2_id;
      r_rd1_vld  <= r_tag2_vld &&  r_tag2_id;
      if (r_tag2_vld && !r_tag2_id) r_rd0_data <= i_sram_dout;
      if (r_tag2_vld &&  r_tag2_id) r_rd1_data <= i_sram_dout;
    end
  end

  assign o_wr_gnt    = w_gnt_wr;
  assign o_rd0_gnt   = w_gnt_rd0;
  assign o_rd1_gnt   = w_gnt_rd1;
  assign o_sram_cs   = r_cs;
  assign o_sram_we   = r_we;
  assign o_sram_addr = r_addr;
  assign o_sram_din  = r_din;
  assign o_rd0_data  = r_rd0_data;
  assign o_rd0_vld   = r_rd0_vld;
  assign o_rd1_data  = r_rd1_data;
  assign o_rd1_vld   = r_rd1_vld;
  assign o_busy      = r_cs | r_tag1_vld | r_tag2_vld;

endmodule
`default_nettype wire

// File: tb/tb_weight_sram_arb.sv
`default_nettype none
// ============================================================================
// tb_weight_sram_arb : directed-vector bench with a behavioural SRAM model
// Rev 1.0
// ============================================================================
module tb_weight_sram_arb;

  logic        clk;
  logic        rst;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_gnt;
  logic        rd0_req;
  logic [15:0] rd0_addr;
  logic        rd0_gnt;
  logic [15:0] rd0_data;
  logic        rd0_vld;
  logic        rd1_req;
  logic [15:0] rd1_addr;
  logic        rd1_gnt;
  logic [15:0] rd1_data;
  logic        rd1_vld;
  logic        sram_cs;
  logic        sram_we;
  logic [15:0] sram_addr;
  logic [15:0] sram_din;
  logic [15:0] sram_dout;
  logic        busy;

  logic [2:0]  grants;
  int          n_vec;
  int          n_err;

  logic [15:0] mem   [0:255];
  logic [255:0] wrote;

  weight_sram_arb #(.AW(16), .DW(16), .STARVE_LIM(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_req    (wr_req),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_wr_gnt    (wr_gnt),
    .i_rd0_req   (rd0_req),
    .i_rd0_addr  (rd0_addr),
    .o_rd0_gnt   (rd0_gnt),
    .o_rd0_data  (rd0_data),
    .o_rd0_vld   (rd0_vld),
    .i_rd1_req   (rd1_req),
    .i_rd1_addr  (rd1_addr),
    .o_rd1_gnt   (rd1_gnt),
    .o_rd1_data  (rd1_data),
    .o_rd1_vld   (rd1_vld),
    .o_sram_cs   (sram_cs),
    .o_sram_we   (sram_we),
    .o_sram_addr (sram_addr),
    .o_sram_din  (sram_din),
    .i_sram_dout (sram_dout),
    .o_busy      (busy)
  );

  assign grants = {wr_gnt, rd1_gnt, rd0_gnt};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unwritten locations read back as {addr,addr}, except 0x05 which holds 0xBEEF.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h05) ? 16'hBEEF : {a, a};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      wrote <= '0;
    end else if (sram_cs) begin
      if (sram_we) begin
        mem[sram_addr[7:0]]   <= sram_din;
        wrote[sram_addr[7:0]] <= 1'b1;
      end else begin
        sram_dout <= wrote[sram_addr[7:0]] ? mem[sram_addr[7:0]] : init_val(sram_addr[7:0]);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) check("onehot", 64'($countones(grants) <= 1), 64'd1);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_req  = 1'b0;
    rd0_req = 1'b0;
    rd1_req = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    sram_dout = 16'h0;
    wr_addr  = 16'h0;
    wr_data  = 16'h0;
    rd0_addr = 16'h0;
    rd1_addr = 16'h0;

    // Reset with requests present: grants must stay low, outputs clear
    rst = 1'b1;
    wr_req = 1'b1; rd0_req = 1'b1; rd1_req = 1'b1;
    next_cycle();
    next_cycle();
    check("rst_gnt", 64'(grants), 64'd0);
    check("rst_cmd", {sram_cs, sram_we, sram_addr, sram_din, busy}, 64'd0);
    check("rst_ret", {rd0_vld, rd1_vld, rd0_data, rd1_data}, 64'd0);
    rst = 1'b0;
    idle();

    // Single read of 0x0005
    next_cycle(); rd0_req = 1'b1; rd0_addr = 16'h0005; #1;
    check("t1_gnt", 64'(grants), 64'b001);
    next_cycle(); rd0_req = 1'b0; #1;
    check("t1_cmd", {sram_cs, sram_we, sram_addr}, {1'b1, 1'b0, 16'h0005});
    check("t1_busy", 64'(busy), 64'd1);
    next_cycle(); #1;
    check("t1_vld_c2", 64'(rd0_vld), 64'd0);
    next_cycle(); #1;
    check("t1_ret_c3", {rd0_vld, rd0_data}, {1'b1, 16'hBEEF});
    next_cycle(); #1;
    check("t1_hold_c4", {rd0_vld, rd0_data, busy}, {1'b0, 16'hBEEF, 1'b0});

    // Write 0x0010<-0x1234 then rd1 reads it the next cycle
    next_cycle(); wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 16'h1234; #1;
    check("t2_wgnt", 64'(grants), 64'b100);
    next_cycle(); wr_req = 1'b0; rd1_req = 1'b1; rd1_addr = 16'h0010; #1;
    check("t2_rgnt", 64'(grants), 64'b010);
    check("t2_wcmd", {sram_cs, sram_we, sram_addr, sram_din}, {1'b1, 1'b1, 16'h0010, 16'h1234});
    next_cycle(); rd1_req = 1'b0; #1;
    check("t2_rcmd", {sram_cs, sram_we, sram_addr}, {1'b1, 1'b0, 16'h0010});
    next_cycle(); #1;
    check("t2_idle", {sram_cs, sram_we, sram_addr}, {1'b0, 1'b0, 16'h0010});
    next_cycle(); #1;
    check("t2_ret", {rd1_vld, rd1_data, rd0_vld}, {1'b1, 16'h1234, 1'b0});

    // Three-way contention with starvation
    do_reset();
    begin
      logic [2:0] exp_g [0:6];
      exp_g[0] = 3'b100; exp_g[1] = 3'b100; exp_g[2] = 3'b100; exp_g[3] = 3'b100;
      exp_g[4] = 3'b001; exp_g[5] = 3'b010; exp_g[6] = 3'b100;
      for (int c = 0; c <= 8; c++) begin
        next_cycle();
        if (c <= 6) begin
          wr_req = 1'b1; wr_addr = 16'h0020; wr_data = 16'hAAAA;
          rd0_req = 1'b1; rd0_addr = 16'h0020;
          rd1_req = 1'b1; rd1_addr = 16'h0030;
        end else begin
          idle();
        end
        #1;
        if (c <= 6) check($sformatf("t3_gnt_c%0d", c), 64'(grants), 64'(exp_g[c]));
        if (c == 7) check("t3_rd0_ret", {rd0_vld, rd0_data}, {1'b1, 16'hAAAA});
        if (c == 8) check("t3_rd1_ret", {rd1_vld, rd1_data}, {1'b1, 16'h3030});
      end
    end

    // Round-robin between continuous readers
    for (int c = 0; c <= 9; c++) begin
      next_cycle();
      if (c < 6) begin
        rd0_req = 1'b1; rd0_addr = 16'h0040;
        rd1_req = 1'b1; rd1_addr = 16'h0050;
      end else begin
        idle();
      end
      #1;
      if (c < 6) check($sformatf("t4_gnt_c%0d", c), 64'(grants), (c % 2 == 0) ? 64'b001 : 64'b010);
      check($sformatf("t4_vld_c%0d", c), {rd0_vld, rd1_vld},
            {(c >= 3 && c <= 7 && c % 2 == 1), (c >= 4 && c <= 8 && c % 2 == 0)});
      if (rd0_vld) check($sformatf("t4_d0_c%0d", c), 64'(rd0_data), 64'h4040);
      if (rd1_vld) check($sformatf("t4_d1_c%0d", c), 64'(rd1_data), 64'h5050);
    end

    // Move pointer to 1 so reset's effect on it is visible
    next_cycle(); rd0_req = 1'b1; rd0_addr = 16'h0005; #1;
    check("t5_pre_gnt", 64'(grants), 64'b001);
    for (int c = 0; c < 4; c++) begin
      next_cycle(); idle();
    end

    // Reset while a read is in flight
    next_cycle(); rd0_req = 1'b1; rd0_addr = 16'h0005; #1;
    check("t5_gnt_c0", 64'(grants), 64'b001);
    next_cycle(); rst = 1'b1; rd1_req = 1'b1; rd1_addr = 16'h0050; #1;
    check("t5_forced_low", 64'(grants), 64'd0);
    next_cycle(); rst = 1'b0; idle(); #1;
    check("t5_zero_cmd", {sram_cs, sram_we, sram_addr, sram_din, rd0_vld, rd1_vld, busy}, 64'd0);
    check("t5_zero_data", {rd0_data, rd1_data}, 64'd0);
    for (int c = 3; c <= 6; c++) begin
      next_cycle();
      if (c == 3) begin
        rd0_req = 1'b1; rd0_addr = 16'h0005;
        rd1_req = 1'b1; rd1_addr = 16'h0050;
      end else begin
        idle();
      end
      #1;
      if (c == 3) check("t5_first_gnt", 64'(grants), 64'b001);
      if (c < 6) check($sformatf("t5_novld_c%0d", c), 64'(rd0_vld), 64'd0);
      else       check("t5_ret_c6", {rd0_vld, rd0_data}, {1'b1, 16'hBEEF});
    end

    // Reader dropping its request clears the wait count
    for (int c = 0; c <= 11; c++) begin
      next_cycle();
      wr_req = (c <= 8); wr_addr = 16'h0060; wr_data = 16'h6666;
      rd0_req = (c <= 8) && (c != 3); rd0_addr = 16'h0060;
      rd1_req = 1'b0;
      #1;
      if (c <= 8) check($sformatf("t6_gnt_c%0d", c), 64'(grants), (c == 8) ? 64'b001 : 64'b100);
      if (c == 11) check("t6_ret", {rd0_vld, rd0_data}, {1'b1, 16'h6666});
    end

    idle();
    next_cycle();
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
